// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel window path: frame size defaults, widths, tap order, FSM states.
package sobel_pkg;

    localparam int MAX_ROW_DEF = 480;
    localparam int MAX_COL_DEF = 640;
    localparam int PIX_W       = 8;
    localparam int WIN_W       = 64;
    localparam int CNT_W       = 10;

    // Tap slot in the packed window; slot k occupies bits [k*8+7 : k*8].
    localparam int TL = 7;
    localparam int TC = 6;
    localparam int TR = 5;
    localparam int ML = 4;
    localparam int MR = 3;
    localparam int BL = 2;
    localparam int BC = 1;
    localparam int BR = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of pixel delay: single-port RAM, read-before-write at a shared address.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = MAX_COL_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [PIX_W-1:0] wr_data_i,
    output logic [PIX_W-1:0] rd_data_o
);

    logic [PIX_W-1:0] mem_q [DEPTH];

    // Asynchronous read hands back the previous line's pixel in the cycle it is overwritten.
    assign rd_data_o = mem_q[addr_i];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster pixel stream in, one 3x3 Sobel window (with centre row/col) out per image position.
// Define WINDOW_REPLICATE_BORDER_EN to clamp out-of-image taps to the nearest pixel instead of 0.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int MAX_ROW = MAX_ROW_DEF,
    parameter int MAX_COL = MAX_COL_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    input  logic             pix_sof,
    output logic             pix_ready,
    output logic [CNT_W-1:0] row,
    output logic [CNT_W-1:0] col,
    output logic [WIN_W-1:0] window,
    output logic             win_valid,
    input  logic             win_ready,
    output logic             frame_done
);

    localparam int               LB_AW  = $clog2(MAX_COL);
    localparam logic [CNT_W-1:0] ROW_LIM = CNT_W'(MAX_ROW);
    localparam logic [CNT_W-1:0] COL_LIM = CNT_W'(MAX_COL);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      vr_q, vr_d;
    logic [CNT_W-1:0]      vc_q, vc_d;
    logic [2:0][PIX_W-1:0] c0_q, c1_q, new_col;
    logic [WIN_W-1:0]      win_q, win_d;
    logic [CNT_W-1:0]      row_q, col_q;
    logic                  win_valid_q;

    logic                  out_free, is_real, adv, restart, shift, emit, ready_c;
    logic [PIX_W-1:0]      cur_pix;
    logic [LB_AW-1:0]      lb_addr;
    logic                  lb_we;
    logic [2:0][PIX_W-1:0] lb_chain;
    logic [PIX_W-1:0]      mc [3][3];
    logic [PIX_W-1:0]      taps [8];
    logic                  top_out, bot_out, left_out, right_out;
    genvar                 gi;

    assign out_free = !win_valid_q || win_ready;
    assign is_real  = (vr_q < ROW_LIM) && (vc_q < COL_LIM);

    always_comb begin
        state_d    = state_q;
        vr_d       = vr_q;
        vc_d       = vc_q;
        adv        = 1'b0;
        restart    = 1'b0;
        ready_c    = 1'b0;
        frame_done = 1'b0;
        cur_pix    = '0;
        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (pix_valid && pix_sof) begin
                    restart = 1'b1;
                end
            end
            FILL, STREAM: begin
                ready_c = is_real && out_free;
                if (is_real) begin
                    if (out_free && pix_valid) begin
                        if (pix_sof) begin
                            restart = 1'b1;
                        end else begin
                            adv     = 1'b1;
                            cur_pix = pix_in;
                        end
                    end
                end else if (out_free) begin
                    adv = 1'b1;
                end
                if (adv) begin
                    if (vc_q == COL_LIM) begin
                        vc_d = '0;
                        if (vr_q == ROW_LIM) begin
                            vr_d    = '0;
                            state_d = DRAIN;
                        end else begin
                            vr_d    = vr_q + 1'b1;
                            state_d = STREAM;
                        end
                    end else begin
                        vc_d = vc_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (win_valid_q && win_ready) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A start-of-frame pixel is always position (0,0), whatever the raster had reached.
        if (restart) begin
            cur_pix = pix_in;
            vr_d    = '0;
            vc_d    = CNT_W'(1);
            state_d = FILL;
        end
    end

    assign shift   = adv || restart;
    assign emit    = adv && (vr_q != '0) && (vc_q != '0);
    assign lb_we   = restart || (adv && (vc_q < COL_LIM));
    assign lb_addr = (restart || !(vc_q < COL_LIM)) ? '0 : vc_q[LB_AW-1:0];

    // Two cascaded line delays: chain[1] is the line above the input, chain[2] two lines above.
    assign lb_chain[0] = cur_pix;
    for (gi = 0; gi < 2; gi++) begin : g_lb
        sobel_line_buffer #(
            .DEPTH(MAX_COL),
            .AW   (LB_AW)
        ) u_lb (
            .clk      (clk),
            .we_i     (lb_we),
            .addr_i   (lb_addr),
            .wr_data_i(lb_chain[gi]),
            .rd_data_o(lb_chain[gi+1])
        );
    end

    assign new_col[0] = lb_chain[2];
    assign new_col[1] = lb_chain[1];
    assign new_col[2] = cur_pix;

    assign top_out   = (vr_q == CNT_W'(1));
    assign bot_out   = (vr_q == ROW_LIM);
    assign left_out  = (vc_q == CNT_W'(1));
    assign right_out = (vc_q == COL_LIM);

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            mc[r][0] = c1_q[r];
            mc[r][1] = c0_q[r];
            mc[r][2] = new_col[r];
        end
`ifdef WINDOW_REPLICATE_BORDER_EN
        for (int r = 0; r < 3; r++) begin
            if (left_out)  mc[r][0] = mc[r][1];
            if (right_out) mc[r][2] = mc[r][1];
        end
        for (int c = 0; c < 3; c++) begin
            if (top_out) mc[0][c] = mc[1][c];
            if (bot_out) mc[2][c] = mc[1][c];
        end
`else
        for (int r = 0; r < 3; r++) begin
            if (left_out)  mc[r][0] = '0;
            if (right_out) mc[r][2] = '0;
        end
        for (int c = 0; c < 3; c++) begin
            if (top_out) mc[0][c] = '0;
            if (bot_out) mc[2][c] = '0;
        end
`endif
        taps[TL] = mc[0][0];
        taps[TC] = mc[0][1];
        taps[TR] = mc[0][2];
        taps[ML] = mc[1][0];
        taps[MR] = mc[1][2];
        taps[BL] = mc[2][0];
        taps[BC] = mc[2][1];
        taps[BR] = mc[2][2];
    end

    for (gi = 0; gi < 8; gi++) begin : g_pack
        assign win_d[gi*PIX_W +: PIX_W] = taps[gi];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            vr_q        <= '0;
            vc_q        <= '0;
            c0_q        <= '0;
            c1_q        <= '0;
            win_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            win_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vr_q    <= vr_d;
            vc_q    <= vc_d;
            if (shift) begin
                c1_q <= c0_q;
                c0_q <= new_col;
            end
            if (emit) begin
                win_valid_q <= 1'b1;
                win_q       <= win_d;
                row_q       <= vr_q - 1'b1;
                col_q       <= vc_q - 1'b1;
            end else if (win_ready) begin
                win_valid_q <= 1'b0;
            end
        end
    end

    assign pix_ready = ready_c & reset;
    assign row       = row_q;
    assign col       = col_q;
    assign window    = win_q;
    assign win_valid = win_valid_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen on a 4x5 frame: raster, backpressure, random valid, resync, reset.
module tb_sobel_window_gen;

    localparam int NR = 4;
    localparam int NC = 5;

    localparam logic [63:0] EXP_11 = 64'h0001021012202122;
`ifdef WINDOW_REPLICATE_BORDER_EN
    localparam logic [63:0] EXP_00 = 64'h0000010001101011;
    localparam logic [63:0] EXP_34 = 64'h2324243334333434;
`else
    localparam logic [63:0] EXP_00 = 64'h0000000001001011;
    localparam logic [63:0] EXP_34 = 64'h2324003300000000;
`endif

    typedef struct {
        logic [9:0]  row;
        logic [9:0]  col;
        logic [63:0] win;
        logic        last;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        pix_sof;
    logic        pix_ready;
    logic [9:0]  row;
    logic [9:0]  col;
    logic [63:0] window;
    logic        win_valid;
    logic        win_ready;
    logic        frame_done;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          fd_count = 0;
    int          fd_exp = 0;
    bit          abort = 0;
    bit          bp_armed = 0;
    bit          capture = 0;
    logic [63:0] cap00, cap11, cap34;

    sobel_window_gen #(
        .MAX_ROW(NR),
        .MAX_COL(NC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_sof   (pix_sof),
        .pix_ready (pix_ready),
        .row       (row),
        .col       (col),
        .window    (window),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] pixv(input int img, input int r, input int c);
        logic [7:0] p;
        p = 8'((r << 4) | c);
        if (img != 0) p = p | 8'h80;
        return p;
    endfunction

    // Reference neighbourhood straight from the image definition.
    function automatic logic [63:0] model_win(input int img, input int r, input int c);
        logic [63:0] w;
        int k, rr, cc;
        w = '0;
        k = 7;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (!(dr == 0 && dc == 0)) begin
                    rr = r + dr;
                    cc = c + dc;
`ifdef WINDOW_REPLICATE_BORDER_EN
                    if (rr < 0) rr = 0;
                    if (rr > NR - 1) rr = NR - 1;
                    if (cc < 0) cc = 0;
                    if (cc > NC - 1) cc = NC - 1;
                    w[k*8 +: 8] = pixv(img, rr, cc);
`else
                    if (rr >= 0 && rr < NR && cc >= 0 && cc < NC)
                        w[k*8 +: 8] = pixv(img, rr, cc);
`endif
                    k--;
                end
            end
        end
        return w;
    endfunction

    task automatic push_frame(input int img, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.row  = 10'(i / NC);
            e.col  = 10'(i % NC);
            e.win  = model_win(img, i / NC, i % NC);
            e.last = ((i / NC) == NR - 1) && ((i % NC) == NC - 1);
            sb.push_back(e);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the pixel was taken (or on abort).
    task automatic push_pix(input logic [7:0] p, input logic sof, input bit rnd);
        int  g;
        bit  took;
        g = 0;
        took = 0;
        if (rnd) begin
            while ($urandom_range(0, 1) == 1 && !abort) begin
                pix_valid = 1'b0;
                pix_sof   = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        pix_in    = p;
        pix_sof   = sof;
        pix_valid = 1'b1;
        while (!took && !abort) begin
            @(negedge clk);
            took = pix_ready;
            @(posedge clk);
            #1;
            g++;
            if (g > 2000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pix_handshake_timeout: got pix_ready=0 for %0d cycles required 1", g);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $fatal(1, "handshake timeout");
            end
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic send_frame(input int img, input int n, input bit rnd);
        @(posedge clk);
        #1;
        for (int i = 0; i < n && !abort; i++) begin
            push_pix(pixv(img, i / NC, i % NC), i == 0, rnd);
        end
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk({"drain_", name}, 128'(sb.size()), 128'd0);
        repeat (3) @(negedge clk);
        chk({"frame_done_count_", name}, 128'(fd_count), 128'(fd_exp));
    endtask

    // Monitor: pops one expected window per accepted output transaction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && frame_done) fd_count++;
            if (reset && win_valid && win_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_window: got r=%0d c=%0d win=%h required no window", row, col, window);
                end else begin
                    e = sb.pop_front();
                    $display("txn r=%0d c=%0d win=%h fd=%0d", row, col, window, frame_done);
                    chk("window", {row, col, window}, {e.row, e.col, e.win});
                    chk("frame_done", 128'(frame_done), 128'(e.last));
                    if (capture) begin
                        if (row == 0 && col == 0) cap00 = window;
                        if (row == 1 && col == 1) cap11 = window;
                        if (row == NR - 1 && col == NC - 1) cap34 = window;
                    end
                end
            end
        end
    end

    // Consumer ready, with a 7-cycle stall at window (2,3) when armed.
    initial begin
        logic [63:0] held;
        win_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (bp_armed && reset && win_valid && row == 2 && col == 3) begin
                bp_armed  = 0;
                held      = window;
                win_ready = 1'b0;
                for (int k = 0; k < 7; k++) begin
                    @(posedge clk);
                    #2;
                    chk("bp_hold", {win_valid, row, col, window}, {1'b1, 10'd2, 10'd3, held});
                    chk("bp_pix_ready", 128'(pix_ready), 128'd0);
                end
                win_ready = 1'b1;
            end
        end
    end

    initial begin
        reset     = 1'b0;
        pix_in    = '0;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        cap00     = '0;
        cap11     = '0;
        cap34     = '0;
        repeat (3) @(negedge clk);
        chk("rst_win_valid", 128'(win_valid), 128'd0);
        chk("rst_pix_ready", 128'(pix_ready), 128'd0);
        chk("rst_frame_done", 128'(frame_done), 128'd0);
        chk("rst_row_col", {row, col}, 128'd0);
        chk("rst_window", 128'(window), 128'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_pix_ready", 128'(pix_ready), 128'd1);

        // Plain raster frame.
        capture = 1;
        push_frame(0, NR * NC);
        send_frame(0, NR * NC, 0);
        fd_exp++;
        wait_drain("raster");
        capture = 0;
        chk("win_0_0", 128'(cap00), 128'(EXP_00));
        chk("win_1_1", 128'(cap11), 128'(EXP_11));
        chk("win_3_4", 128'(cap34), 128'(EXP_34));

        // Backpressure at (2,3).
        bp_armed = 1;
        push_frame(0, NR * NC);
        send_frame(0, NR * NC, 0);
        fd_exp++;
        wait_drain("backpressure");
        chk("bp_fired", 128'(bp_armed), 128'd0);

        // Random gaps on pix_valid.
        push_frame(0, NR * NC);
        send_frame(0, NR * NC, 1);
        fd_exp++;
        wait_drain("random_valid");

        // Resync: SOF replaces input pixel (2,2).
        push_frame(0, 6);
        push_frame(1, NR * NC);
        send_frame(0, 12, 0);
        send_frame(1, NR * NC, 0);
        fd_exp++;
        wait_drain("resync");

        // Asynchronous reset at window (1,3).
        push_frame(0, NR * NC);
        fork
            send_frame(0, NR * NC, 0);
            begin
                int k;
                k = 0;
                while (!(win_valid && row == 1 && col == 3) && k < 2000) begin
                    @(negedge clk);
                    k++;
                end
                chk("rst_trigger_seen", 128'(k < 2000), 128'd1);
                #3;
                reset = 1'b0;
                abort = 1;
                #1;
                chk("async_win_valid", 128'(win_valid), 128'd0);
                chk("async_pix_ready", 128'(pix_ready), 128'd0);
                chk("async_frame_done", 128'(frame_done), 128'd0);
                sb.delete();
                repeat (2) @(negedge clk);
                reset = 1'b1;
            end
        join
        abort = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) push_pix(8'hAA, 1'b0, 0);
        repeat (6) @(negedge clk);
        chk("idle_no_window", 128'(win_valid), 128'd0);
        chk("idle_sb_empty", 128'(sb.size()), 128'd0);
        push_frame(0, NR * NC);
        send_frame(0, NR * NC, 0);
        fd_exp++;
        wait_drain("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Producer end of the Sobel window interface.
- Accepts a raster-order 8-bit pixel stream, one pixel per handshake.
- Buffers two image lines and emits, for every image position, the 64-bit 3x3 neighbourhood in the Sobel input format, together with that position's row/col.
- Sits between the pixel source (camera/frame RAM) and sobel_blackBorder; exactly MAX_ROW*MAX_COL windows are emitted per frame.

Parameters:
- MAX_ROW, 480, image height in lines; row counters are 10 bits.
- MAX_COL, 640, image width in pixels; col counters and line-buffer address are 10 bits.

Ports:
- clk  input  1  pixel clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- pix_in  input  8  input pixel.
- pix_valid  input  1  pix_in valid.
- pix_sof  input  1  qualifies pix_in as pixel (0,0) of a new frame.
- pix_ready  output  1  block accepts pix_in this cycle.
- row  output  10  centre row of the emitted window.
- col  output  10  centre column of the emitted window.
- window  output  64  {top_left, top, top_right, mid_left, mid_right, bot_left, bot, bot_right}; top_left is in [63:56].
- win_valid  output  1  window/row/col valid.
- win_ready  input  1  consumer accepts the window.
- frame_done  output  1  one-cycle pulse when window (MAX_ROW-1, MAX_COL-1) is accepted.

Behaviour:
- Reset (async, reset=0):
  - Outputs: win_valid=0, pix_ready=0, frame_done=0, row=0, col=0, window=0.
  - Counters vr/vc=0; FSM enters IDLE.
  - Line buffers are not cleared.
- Virtual raster: positions (vr,vc), vr in 0..MAX_ROW, vc in 0..MAX_COL.
  - A position is real if vr<MAX_ROW and vc<MAX_COL. A real position consumes one input pixel.
  - Otherwise it is pad: value 0, generated internally in one cycle, nothing consumed.
- Advancing a position:
  - Shifts the value into the 3x3 shift registers and writes line buffers read-before-write at address vc.
  - Increments vc; vc wraps from MAX_COL to 0 with vr+1.
- Emission: advancing position (vr,vc) with vr>=1 and vc>=1 loads the output register one cycle later with centre (vr-1, vc-1).
- Out-of-image taps (centre row 0 top taps, centre col 0 left taps, last-row bottom taps, last-col right taps) are forced to 0.
- Handshake:
  - Output stage is a single register. It advances when !win_valid || win_ready.
  - A held window and its row/col stay stable while win_valid=1 && win_ready=0.
  - pix_ready = (state is FILL or STREAM) && the current position is real && the output stage can advance.
  - Pad positions stall identically on backpressure.
- FSM:
  - IDLE: pix_ready=1; waits for pix_valid && pix_sof, then enters STREAM. pix_valid without sof is discarded (accepted, ignored).
  - STREAM: advances real and pad positions. After position (MAX_ROW, MAX_COL) is advanced, enters DRAIN.
  - DRAIN: waits for the last window to be accepted, pulses frame_done, returns to IDLE.
  - FILL: alias of STREAM for vr=0, in which no windows are emitted.
- pix_sof accepted in STREAM/FILL (mid-frame resync):
  - Counters reset to (0,0) and that pixel is taken as (0,0).
  - A window already in the output register is still delivered.
  - No frame_done is emitted for the aborted frame.
- Latency: window for centre (r,c) is presented 1 cycle after position (r+1,c+1) is advanced.
  - Steady-state throughput is 1 window/cycle, with one pad cycle per line and MAX_COL+1 pad cycles at frame end.
- pix_valid and pix_sof are ignored in DRAIN (pix_ready=0).

Optional Feature:
- WINDOW_REPLICATE_BORDER_EN:
  - Defined: out-of-image taps take the nearest in-image pixel (clamped row/col).
  - Undefined: out-of-image taps are 0.
- sobel_blackBorder blackens edges either way. The macro exists for filters that use edge pixels.

Decomposition:
- Shared package sobel_pkg holds:
  - MAX_ROW/MAX_COL defaults.
  - PIX_W=8 and WIN_W=64.
  - Tap index constants (TL=7 ... BR=0) matching the window bit order.
  - FSM state encoding (IDLE, FILL, STREAM, DRAIN).
- One sub-module, sobel_line_buffer:
  - MAX_COL x 8 single-port, read-before-write delay line.
  - Instantiated twice, cascaded.

Test Plan:
- MAX_ROW=4, MAX_COL=5, pix=(r<<4)|c, no backpressure -> 20 windows in raster order. The (1,1) window is 64'h00_01_02_10_12_20_21_22. frame_done pulses once after (3,4).
- Same frame, corner (0,0) -> window 64'h00_00_00_00_01_00_10_11. With WINDOW_REPLICATE_BORDER_EN -> 64'h00_00_01_00_01_10_10_11.
- win_ready held 0 for 7 cycles at window (2,3) -> window/row/col stable throughout, pix_ready=0, no pixel lost, and the following window is (2,4).
- pix_valid toggled randomly at 50% -> identical window sequence to the first scenario.
- pix_sof reasserted at input pixel (2,2) -> frame restarts with windows (0,0)... from the new data, no frame_done for the aborted frame, full 20 windows after resync.
- reset driven low mid-frame (at window (1,3)) -> win_valid, pix_ready and frame_done are 0 asynchronously. After release the block waits in IDLE for pix_sof, then produces a correct frame.
